// File: rtl/seven_segment_scanner_if.sv
// Connection bundle between a nibble-producing datapath and the seven-segment scanner.
// The datapath owns the display value and controls; the scanner owns the pin-level outputs.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                lz_en;
  logic                en;
  logic [DIGITS-1:0]   anode_active;
  logic [6:0]          segments;
  logic                dp;
  logic                frame_done;

  modport master (
    output digits_in, dp_in, load, lz_en, en,
    input  anode_active, segments, dp, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, lz_en, en,
    output anode_active, segments, dp, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed multi-digit seven-segment driver with a double-buffered display value,
// hex/decimal decode, decimal points, leading-zero suppression and a global blank.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit HEX_MODE    = 1'b0,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  seven_segment_scanner_if.slave bus
);

  localparam int RC_W  = $clog2(REFRESH_DIV);
  localparam int POS_W = $clog2(DIGITS);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DIGITS - 1);

  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};

  logic [RC_W-1:0]     rc;
  logic [POS_W-1:0]    pos;
  logic [4*DIGITS-1:0] disp_nib;
  logic [DIGITS-1:0]   disp_dp;
  logic [4*DIGITS-1:0] pend_nib;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_v;
  logic                wrap_q;

  logic                tc;
  logic                wrap;
  logic [POS_W-1:0]    idx;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   lead_blank;
  logic                zero_run;
  logic [DIGITS-1:0]   anode_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB:    s = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC:    s = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD:    s = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE:    s = HEX_MODE ? 7'b1001111 : 7'b0000000;
      default: s = HEX_MODE ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  assign tc   = (rc == RC_LAST);
  assign wrap = tc && (pos == POS_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc  <= '0;
      pos <= '0;
    end else begin
      rc <= tc ? '0 : rc + 1'b1;
      if (tc) pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
    end
  end

  // A load on the wrap edge bypasses the pending stage so it shows in the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_nib <= '0;
      disp_dp  <= '0;
      pend_nib <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
    end else if (wrap) begin
      if (bus.load) begin
        disp_nib <= bus.digits_in;
        disp_dp  <= bus.dp_in;
      end else if (pend_v) begin
        disp_nib <= pend_nib;
        disp_dp  <= pend_dp;
      end
      pend_v <= 1'b0;
    end else if (bus.load) begin
      pend_nib <= bus.digits_in;
      pend_dp  <= bus.dp_in;
      pend_v   <= 1'b1;
    end
  end

  // Leftmost digit is scanned first.
  assign idx = POS_LAST - pos;
  assign nib = disp_nib[4*idx +: 4];

  // NOTE: every always_comb output gets a default before any conditional logic,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    lead_blank = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (disp_nib[4*k +: 4] == 4'h0);
      lead_blank[k] = zero_run && (k != 0);
    end
  end

  always_comb begin
    anode_next = '0;
    seg_next   = '0;
    dp_next    = 1'b0;
    if (bus.en) begin
      anode_next = DIGITS'(1) << idx;
      dp_next    = disp_dp[idx];
      if (!(bus.lz_en && lead_blank[idx])) seg_next = decode(nib);
    end
  end

  // Outputs are stored at pin polarity so reset drives the pins dark directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.anode_active <= ANODE_OFF;
      bus.segments     <= SEG_OFF;
      bus.dp           <= ACTIVE_LOW;
      wrap_q           <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.anode_active <= anode_next ^ ANODE_OFF;
      bus.segments     <= seg_next ^ SEG_OFF;
      bus.dp           <= dp_next ^ ACTIVE_LOW;
      wrap_q           <= wrap;
      bus.frame_done   <= wrap_q;
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised, self-scanning multi-digit seven-segment display driver. It replaces the per-digit combinational decoder with a block that time-multiplexes `DIGITS` digits from a single clock, with a double-buffered display value, hex/decimal decode, decimal points, leading-zero suppression and a global blank. It sits between the datapath that produces BCD/hex nibbles and the board's anode/segment pins.

## Interface
- `DIGITS`, 4, number of digits; ≥2
- `REFRESH_DIV`, 100000, clock cycles each digit is driven; ≥2
- `HEX_MODE`, 0, 1: nibbles A–F decode to letters; 0: nibbles >9 blank
- `ACTIVE_LOW`, 1, 1: anodes, segments and dp are lit at 0; 0: lit at 1
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `digits_in`  in  4*DIGITS  nibble i = `digits_in[4i+3:4i]`; digit DIGITS-1 is leftmost/most significant
- `dp_in`  in  DIGITS  decimal point per digit, 1 = lit
- `load`  in  1  capture `digits_in`/`dp_in` into pending buffer
- `lz_en`  in  1  1 = suppress leading zeros
- `en`  in  1  0 = all digits dark; scanning continues
- `anode_active`  out  DIGITS  one-hot digit strobe (polarity per ACTIVE_LOW)
- `segments`  out  7  bit6=a … bit0=g
- `dp`  out  1  decimal point of driven digit
- `frame_done`  out  1  one-cycle pulse at each frame wrap

## Operation
- Refresh counter `rc` counts 0..REFRESH_DIV-1, wraps; terminal count (`rc==REFRESH_DIV-1`) advances scan position `pos` (0..DIGITS-1, wraps to 0).
- Driven digit index = DIGITS-1-pos: leftmost digit first, rightmost last.
- Double buffer: `load`=1 copies inputs into pending register and sets `pend_v`. On frame wrap (terminal count with pos==DIGITS-1), if `pend_v`, display register ← pending and `pend_v` clears. Display never changes mid-frame.
- `load` coinciding with frame wrap: the loaded values go straight to the display register; `pend_v` ends 0.
- `load` while `pend_v`=1 (not at wrap): pending overwritten; last load wins.
- Decode (logical, lit=1): 0→1111110, 1→0110000, 2→1101101, 3→1111001, 4→0110011, 5→1011011, 6→1011111, 7→1110000, 8→1111111, 9→1111011; HEX_MODE=1: A→1110111, b→0011111, C→1001110, d→0111101, E→1001111, F→1000111; HEX_MODE=0: 10–15→0000000.
- Leading-zero suppression (`lz_en`=1): digit k is blank (segments off) if digit k and every digit above it in the display register are 0; digit 0 never suppressed. Suppressed digit's dp still follows `dp_in`. `lz_en` evaluated live.
- `en`=0: all anodes inactive; `segments`/`dp` undefined-but-off (all off); counters and buffers keep running.
- Physical output = logical value XOR {ACTIVE_LOW replicated}.

## Timing
- Reset (async, immediate): `rc`=0, `pos`=0, display/pending registers=0, `pend_v`=0; `anode_active` all inactive, `segments` all off, `dp` off, `frame_done`=0.
- All outputs registered: outputs reflect `pos`/display register of the previous cycle (1-cycle latency).
- First rising edge after reset release: digit DIGITS-1 driven, showing display register (0 → "0", or blank if `lz_en` and DIGITS-1>0).
- Each digit active exactly REFRESH_DIV cycles; frame = DIGITS*REFRESH_DIV cycles.
- `frame_done` high in the cycle after the wrap edge, concurrent with the first cycle that shows new display data.
- Reset mid-frame: everything returns to reset values immediately, pending load discarded.

## Test plan
- DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, en=1: after reset, `anode_active` sequence 0111,1011,1101,1110 each 4 cycles, repeating; `frame_done` every 16 cycles.
- load `digits_in`=16'h1234 mid-frame -> display stays 0000 until wrap, then digits show segments 1001111, 0010010, 0000110, 1001100 in scan order.
- HEX_MODE=0 vs 1, load 16'hABCD -> blank (1111111) on all digits vs 0001000, 1100000, 0110001, 1000010.
- lz_en=1, load 16'h0050 -> digits 3,2 blank, digit1 "5", digit0 "0"; load 16'h0000 -> only digit 0 shows "0".
- load asserted on wrap cycle with 16'h9876, plus a second load mid-next-frame -> 9876 visible immediately after wrap; second value only after the following wrap.
- rst pulsed mid-frame with `pend_v`=1 -> outputs all 1 asynchronously; pending value never displayed.
